// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out a 10-bit frame on
// device clock falling edges, then check the device ACK, with start and transfer timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int REQ_CYCLES     = 25,
  parameter int START_TIMEOUT  = 375000,
  parameter int XFER_TIMEOUT   = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       app_clk,
  input  logic       app_arst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_IR  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_TO  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_ALL = (MAX_IR > MAX_TO) ? MAX_IR : MAX_TO;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int FLT_W   = $clog2(FILTER_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_ABORT
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0] pin_raw;
  logic [1:0] pin_filt;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]       sync_reg;
      logic [FLT_W-1:0] flt_cnt_reg;
      logic             filt_reg;

      always_ff @(posedge app_clk) begin
        if (!app_arst_n) begin
          sync_reg    <= 2'b11;
          flt_cnt_reg <= '0;
          filt_reg    <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], pin_raw[gi]};
          // The filtered level only follows after FILTER_LEN consecutive differing samples.
          if (sync_reg[1] == filt_reg) begin
            flt_cnt_reg <= '0;
          end else if (flt_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
            filt_reg    <= sync_reg[1];
            flt_cnt_reg <= '0;
          end else begin
            flt_cnt_reg <= flt_cnt_reg + 1'b1;
          end
        end
      end

      assign pin_filt[gi] = filt_reg;
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_sat;
  logic [9:0]       shift_reg, shift_next;
  logic [3:0]       edge_cnt_reg, edge_cnt_next;
  logic             data_bit_reg, data_bit_next;
  logic [1:0]       status_reg, status_next;
  logic             clk_filt_d_reg;
  logic             fe;

  assign fe       = clk_filt_d_reg & ~pin_filt[0];
  assign cnt_sat  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
  assign tx_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign status   = status_reg;

  always_ff @(posedge app_clk) begin
    if (!app_arst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      edge_cnt_reg   <= '0;
      data_bit_reg   <= 1'b0;
      status_reg     <= 2'b00;
      clk_filt_d_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      edge_cnt_reg   <= edge_cnt_next;
      data_bit_reg   <= data_bit_next;
      status_reg     <= status_next;
      clk_filt_d_reg <= pin_filt[0];
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    edge_cnt_next = edge_cnt_reg;
    data_bit_next = data_bit_reg;
    status_next   = status_reg;
    done          = 1'b0;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          shift_next    = {1'b1, ~^tx_data, tx_data};
          cnt_next      = '0;
          edge_cnt_next = '0;
          state_next    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = S_REQ;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt_reg == CNT_W'(REQ_CYCLES - 1)) begin
          cnt_next      = '0;
          data_bit_next = 1'b1;
          state_next    = S_SEND;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      S_SEND: begin
        ps2_data_oe = data_bit_reg;
        if (fe) begin
          data_bit_next = ~shift_reg[0];
          shift_next    = {1'b0, shift_reg[9:1]};
          edge_cnt_next = edge_cnt_reg + 4'd1;
          // The first device edge restarts the counter as the transfer timer.
          cnt_next      = (edge_cnt_reg == 4'd0) ? CNT_W'(1) : cnt_sat;
          if (edge_cnt_reg == 4'd9) state_next = S_ACK;
        end else if (edge_cnt_reg == 4'd0 && cnt_reg >= CNT_W'(START_TIMEOUT - 1)) begin
          status_next = 2'b10;
          state_next  = S_ABORT;
        end else if (edge_cnt_reg != 4'd0 && cnt_reg >= CNT_W'(XFER_TIMEOUT - 1)) begin
          status_next = 2'b11;
          state_next  = S_ABORT;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      S_ACK: begin
        if (fe) begin
          status_next = pin_filt[1] ? 2'b01 : 2'b00;
          state_next  = S_WAIT_IDLE;
        end else if (cnt_reg >= CNT_W'(XFER_TIMEOUT - 1)) begin
          status_next = 2'b11;
          state_next  = S_ABORT;
        end else begin
          cnt_next = cnt_sat;
        end
      end
      S_WAIT_IDLE: begin
        if (pin_filt == 2'b11) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ABORT: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
